// File: rtl/prbs26_checker_if.sv
// Stream port bundle for the PRBS26 checker: serial data in, lock/error status out.
// din_valid qualifies din for one cycle; there is no ready, the checker accepts every valid bit.
interface prbs26_checker_if;
  logic        din_valid;
  logic        din;
  logic        clr_cnt;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;

  modport master (
    output din_valid, din, clr_cnt,
    input  locked, err, err_cnt, dbg_state
  );

  modport slave (
    input  din_valid, din, clr_cnt,
    output locked, err, err_cnt, dbg_state
  );
endinterface

// File: rtl/prbs26_checker.sv
// PRBS26 (x^26+x^8+x^7+x+1) stream checker: fills history, searches for lock,
// then counts bit errors with windowed loss-of-lock detection.
module prbs26_checker #(
  parameter int LOCK_MATCH = 32,
  parameter int WIN        = 64,
  parameter int LOSS_ERRS  = 8
) (
  input  logic            clk,
  input  logic            rst,
  prbs26_checker_if.slave bus
);

  localparam int MW = $clog2(LOCK_MATCH + 1);
  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(LOSS_ERRS + 1);

  localparam logic [4:0]    FILL_LAST  = 5'd25;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCH - 1);
  localparam logic [WW-1:0] WBIT_LAST  = WW'(WIN - 1);
  localparam logic [EW-1:0] WERR_LAST  = EW'(LOSS_ERRS - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [25:0]   hist_q, hist_d;
  logic [4:0]    fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [WW-1:0] wbit_q, wbit_d;
  logic [EW-1:0] werr_q, werr_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic pred;
  logic miss;
  logic hit_err;

  // hist_q[k-1] holds the bit entered k valid cycles ago
  assign pred = hist_q[17] ^ hist_q[18] ^ hist_q[24] ^ hist_q[25];
  assign miss = bus.din ^ pred;

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    wbit_d    = wbit_q;
    werr_d    = werr_q;
    err_d     = 1'b0;
    hit_err   = 1'b0;
    err_cnt_d = err_cnt_q;

    if (bus.din_valid) begin
      case (state_q)
        FILL: begin
          hist_d = {hist_q[24:0], bus.din};
          fill_d = fill_q + 5'd1;
          if (fill_q == FILL_LAST) begin
            state_d = SEARCH;
            match_d = '0;
          end
        end
        SEARCH: begin
          hist_d = {hist_q[24:0], bus.din};
          // An all-zero history predicts zeros forever, so it must never count toward lock
          if (miss || (hist_q == 26'd0)) begin
            match_d = '0;
          end else begin
            match_d = match_q + MW'(1);
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              wbit_d  = '0;
              werr_d  = '0;
            end
          end
        end
        LOCKED: begin
          // Feeding the prediction back keeps one corrupted bit from causing later misses
          hist_d  = {hist_q[24:0], pred};
          err_d   = miss;
          hit_err = miss;
          if (miss && (werr_q == WERR_LAST)) begin
            state_d = SEARCH;
            match_d = '0;
            wbit_d  = '0;
            werr_d  = '0;
          end else if (wbit_q == WBIT_LAST) begin
            wbit_d = '0;
            werr_d = '0;
          end else begin
            wbit_d = wbit_q + WW'(1);
            werr_d = werr_q + EW'(miss);
          end
        end
        default: state_d = FILL;
      endcase
    end

    if (bus.clr_cnt) begin
      err_cnt_d = {15'd0, hit_err};
    end else if (hit_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      wbit_q    <= '0;
      werr_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      wbit_q    <= wbit_d;
      werr_q    <= werr_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_prbs26_checker.sv
// Directed bench for prbs26_checker; the stream comes from a Galois LFSR model
// stepped by multiply-by-x modulo x^26+x^8+x^7+x+1, output taken from bit 26.
module tb_prbs26_checker;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  prbs26_checker_if bus ();
  prbs26_checker_if bus2 ();

  prbs26_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Short window keeps errors per window below the loss threshold, so every bit can be an error
  prbs26_checker #(.LOCK_MATCH(32), .WIN(4), .LOSS_ERRS(8)) dut_sat (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [25:0] gen;

  task automatic next_bit(output logic b);
    b   = gen[25];
    gen = {gen[24:0], 1'b0};
    if (b) gen = gen ^ 26'h0000183;
  endtask

  task automatic step(input logic v, input logic b);
    bus.din_valid = v;
    bus.din       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic v, input logic b, input logic clr);
    bus2.din_valid = v;
    bus2.din       = b;
    bus2.clr_cnt   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_main();
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    gen = 26'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clr_cnt = 1'b0;
    step(1'b1, 1'b1);
    bus.clr_cnt = 1'b1;
    step(1'b1, 1'b0);
    bus.clr_cnt = 1'b0;
    rst = 1'b0;
    n_checks++;
    if (bus.locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", bus.locked); else n_pass++;
    n_checks++;
    if (bus.err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err); else n_pass++;
    n_checks++;
    if (bus.err_cnt !== 16'd0) $display("FAIL reset_err_cnt got=%h exp=0000", bus.err_cnt); else n_pass++;
    n_checks++;
    if (bus.dbg_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", bus.dbg_state); else n_pass++;
  endtask

  task automatic test_lock_clean();
    logic b;
    int early = 0;
    int errs = 0;
    int drops = 0;
    gen = 26'd1;
    for (int n = 1; n <= 58; n++) begin
      next_bit(b);
      step(1'b1, b);
      if (n == 26) begin
        n_checks++;
        if (bus.dbg_state !== 2'd1) $display("FAIL fill_to_search got=%0d exp=1", bus.dbg_state); else n_pass++;
      end
      if (n < 58 && bus.locked === 1'b1) early++;
    end
    n_checks++;
    if (early !== 0) $display("FAIL lock_early got=%0d exp=0", early); else n_pass++;
    n_checks++;
    if (bus.locked !== 1'b1) $display("FAIL lock_at_58 got=%b exp=1", bus.locked); else n_pass++;
    for (int n = 59; n <= 10000; n++) begin
      next_bit(b);
      step(1'b1, b);
      if (bus.err !== 1'b0) errs++;
      if (bus.locked !== 1'b1) drops++;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL clean_err_pulses got=%0d exp=0", errs); else n_pass++;
    n_checks++;
    if (drops !== 0) $display("FAIL clean_lock_drops got=%0d exp=0", drops); else n_pass++;
    n_checks++;
    if (bus.err_cnt !== 16'd0) $display("FAIL clean_err_cnt got=%h exp=0000", bus.err_cnt); else n_pass++;
  endtask

  task automatic test_single_error();
    logic b;
    int errs = 0;
    next_bit(b);
    step(1'b1, ~b);
    n_checks++;
    if (bus.err !== 1'b1) $display("FAIL single_err_pulse got=%b exp=1", bus.err); else n_pass++;
    for (int n = 0; n < 64; n++) begin
      next_bit(b);
      step(1'b1, b);
      if (bus.err !== 1'b0) errs++;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL single_extra_pulses got=%0d exp=0", errs); else n_pass++;
    n_checks++;
    if (bus.err_cnt !== 16'd1) $display("FAIL single_err_cnt got=%h exp=0001", bus.err_cnt); else n_pass++;
    n_checks++;
    if (bus.locked !== 1'b1) $display("FAIL single_locked got=%b exp=1", bus.locked); else n_pass++;
  endtask

  task automatic test_loss_relock();
    logic b;
    int flips = 0;
    reset_main();
    for (int n = 1; n <= 58; n++) begin
      next_bit(b);
      step(1'b1, b);
    end
    n_checks++;
    if (bus.locked !== 1'b1) $display("FAIL loss_prelock got=%b exp=1", bus.locked); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      next_bit(b);
      if (i % 2 == 1) begin
        step(1'b1, ~b);
        flips++;
        if (flips == 7) begin
          n_checks++;
          if (bus.locked !== 1'b1) $display("FAIL loss_after7 got=%b exp=1", bus.locked); else n_pass++;
        end
      end else begin
        step(1'b1, b);
      end
    end
    n_checks++;
    if (bus.locked !== 1'b0) $display("FAIL loss_after8 got=%b exp=0", bus.locked); else n_pass++;
    n_checks++;
    if (bus.err !== 1'b1) $display("FAIL loss_err8 got=%b exp=1", bus.err); else n_pass++;
    n_checks++;
    if (bus.err_cnt !== 16'd8) $display("FAIL loss_err_cnt got=%h exp=0008", bus.err_cnt); else n_pass++;
    for (int n = 1; n <= 32; n++) begin
      next_bit(b);
      step(1'b1, b);
      if (n == 31) begin
        n_checks++;
        if (bus.locked !== 1'b0) $display("FAIL relock_early got=%b exp=0", bus.locked); else n_pass++;
      end
    end
    n_checks++;
    if (bus.locked !== 1'b1) $display("FAIL relock_32 got=%b exp=1", bus.locked); else n_pass++;
  endtask

  task automatic test_zero_stream();
    int seen = 0;
    reset_main();
    for (int n = 0; n < 200; n++) begin
      step(1'b1, 1'b0);
      if (bus.locked !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL zero_lock_cycles got=%0d exp=0", seen); else n_pass++;
    n_checks++;
    if (bus.dbg_state !== 2'd1) $display("FAIL zero_state got=%0d exp=1", bus.dbg_state); else n_pass++;
  endtask

  task automatic test_valid_gaps();
    logic b;
    logic v;
    int nvalid = 0;
    int cyc = 0;
    int early = 0;
    int errs = 0;
    int drops = 0;
    reset_main();
    while (nvalid < 58 && cyc < 2000) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        next_bit(b);
        nvalid++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      step(v, b);
      cyc++;
      if (nvalid < 58 && bus.locked === 1'b1) early++;
      if (bus.err !== 1'b0) errs++;
    end
    n_checks++;
    if (nvalid !== 58) $display("FAIL gaps_timeout got=%0d exp=58", nvalid); else n_pass++;
    n_checks++;
    if (early !== 0) $display("FAIL gaps_lock_early got=%0d exp=0", early); else n_pass++;
    n_checks++;
    if (bus.locked !== 1'b1) $display("FAIL gaps_lock got=%b exp=1", bus.locked); else n_pass++;
    for (int n = 0; n < 100; n++) begin
      v = 1'($urandom_range(0, 1));
      if (v) next_bit(b);
      else b = 1'($urandom_range(0, 1));
      step(v, b);
      if (bus.err !== 1'b0) errs++;
      if (bus.locked !== 1'b1) drops++;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL gaps_err_pulses got=%0d exp=0", errs); else n_pass++;
    n_checks++;
    if (drops !== 0) $display("FAIL gaps_lock_drops got=%0d exp=0", drops); else n_pass++;
  endtask

  task automatic test_saturation();
    logic b;
    rst2 = 1'b1;
    step2(1'b1, 1'b1, 1'b0);
    rst2 = 1'b0;
    gen = 26'd1;
    for (int n = 1; n <= 58; n++) begin
      next_bit(b);
      step2(1'b1, b, 1'b0);
    end
    n_checks++;
    if (bus2.locked !== 1'b1) $display("FAIL sat_prelock got=%b exp=1", bus2.locked); else n_pass++;
    for (int n = 0; n < 65535; n++) begin
      next_bit(b);
      step2(1'b1, ~b, 1'b0);
    end
    n_checks++;
    if (bus2.err_cnt !== 16'hFFFF) $display("FAIL sat_reach got=%h exp=ffff", bus2.err_cnt); else n_pass++;
    next_bit(b);
    step2(1'b1, ~b, 1'b0);
    n_checks++;
    if (bus2.err_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", bus2.err_cnt); else n_pass++;
    n_checks++;
    if (bus2.locked !== 1'b1) $display("FAIL sat_locked got=%b exp=1", bus2.locked); else n_pass++;
    next_bit(b);
    step2(1'b1, ~b, 1'b1);
    n_checks++;
    if (bus2.err_cnt !== 16'd1) $display("FAIL clr_with_err got=%h exp=0001", bus2.err_cnt); else n_pass++;
    step2(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus2.err_cnt !== 16'd0) $display("FAIL clr_idle got=%h exp=0000", bus2.err_cnt); else n_pass++;
    n_checks++;
    if (bus2.locked !== 1'b1) $display("FAIL clr_keeps_lock got=%b exp=1", bus2.locked); else n_pass++;
    next_bit(b);
    step2(1'b1, ~b, 1'b0);
    rst2 = 1'b1;
    next_bit(b);
    step2(1'b1, ~b, 1'b0);
    rst2 = 1'b0;
    step2(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus2.locked !== 1'b0) $display("FAIL rst_locked got=%b exp=0", bus2.locked); else n_pass++;
    n_checks++;
    if (bus2.err_cnt !== 16'd0) $display("FAIL rst_err_cnt got=%h exp=0000", bus2.err_cnt); else n_pass++;
    n_checks++;
    if (bus2.err !== 1'b0) $display("FAIL rst_err got=%b exp=0", bus2.err); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    bus.din_valid = 1'b0;
    bus.din = 1'b0;
    bus.clr_cnt = 1'b0;
    bus2.din_valid = 1'b0;
    bus2.din = 1'b0;
    bus2.clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lock_clean();
    test_single_error();
    test_loss_relock();
    test_zero_stream();
    test_valid_gaps();
    bus.din_valid = 1'b0;
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs26_checker.md
PRBS26_CHECKER -- requirements
Module: prbs26_checker

Interface
REQ-001 Parameter LOCK_MATCH, default 32: consecutive correct predictions required to declare lock.
REQ-002 Parameter WIN, default 64: length, in valid bits, of the loss-of-lock observation window.
REQ-003 Parameter LOSS_ERRS, default 8: errors within one window that force loss of lock.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 din_valid  input  1: din carries one stream bit this cycle.
REQ-007 din  input  1: received serial bit, i.e. bit 26 of the team's 26-bit Galois PRBS generator, one bit per advance.
REQ-008 clr_cnt  input  1: synchronous clear of err_cnt.
REQ-009 locked  output  1: high while in state LOCKED.
REQ-010 err  output  1: one-cycle pulse per detected bit error while locked.
REQ-011 err_cnt  output  16: saturating count of detected errors.

Function
REQ-012 Polynomial x^26+x^8+x^7+x+1; predicted bit p = h[18]^h[19]^h[25]^h[26], where h[k] is the history bit entered k valid cycles earlier.
REQ-013 History: 26-bit shift register, advancing only on din_valid=1; on din_valid=0 all state, counters and outputs hold (err low).
REQ-014 States FILL, SEARCH, LOCKED; reset state FILL.
REQ-015 FILL: shift din into history; fill counter 0..26; after the 26th valid bit -> SEARCH with match counter 0.
REQ-016 SEARCH: compare din with p; shift din (received bit) into history; match increments match counter, mismatch clears it to 0.
REQ-017 SEARCH: an all-zero history counts as a mismatch (no lock on an all-zero stream).
REQ-018 SEARCH -> LOCKED on the valid cycle the match counter reaches LOCK_MATCH; window bit and error counters clear to 0.
REQ-019 LOCKED: shift p (not din) into history, so each corrupted received bit is counted exactly once.
REQ-020 LOCKED: din != p -> err=1 on the next cycle and err_cnt increments; window error counter increments.
REQ-021 LOCKED: window bit counter runs 0..WIN-1; at wrap both window counters clear to 0.
REQ-022 LOCKED -> SEARCH on the valid cycle the window error counter reaches LOSS_ERRS (takes precedence over wrap); match counter 0; history continues from received bits.
REQ-023 Outputs registered: locked and err change one cycle after the deciding valid sample.
REQ-024 err_cnt saturates at 0xFFFF, no wrap.
REQ-025 clr_cnt=1: err_cnt <= 0, or 1 if an error is detected in the same cycle; clr_cnt has no effect on state or locked.

Reset
REQ-026 rst=1 at an edge: state FILL; history, fill, match and window counters 0; locked=0, err=0, err_cnt=0.
REQ-027 rst overrides din_valid and clr_cnt, and aborts any state mid-operation, with no residual lock.

Verification
REQ-028 Generator seeded 26'b1, clean stream: locked=0 through bit 26+LOCK_MATCH-1; locked=1 one cycle after valid bit 58; err_cnt stays 0 over 10000 bits.
REQ-029 Locked, single bit flipped: exactly one err pulse; err_cnt=1; locked stays 1.
REQ-030 Locked, 8 flipped bits within one 64-bit window: locked drops after the 8th error and err_cnt=8; the clean stream then relocks after 32 matches.
REQ-031 All-zero stream of 200 valid bits: locked never asserts.
REQ-032 din_valid toggled randomly on a clean stream: lock time counts valid bits only; err never pulses.
REQ-033 err_cnt preloaded to 0xFFFF by forced errors: stays 0xFFFF; clr_cnt coincident with an error gives 1; rst while locked gives locked=0 and err_cnt=0 next cycle.
